// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Round-robin arbiter that shares one UART transmitter between up to eight
// byte producers. In IDLE it picks the next requester (searching from the
// round-robin pointer), captures that requester's byte, and issues a start
// pulse to the transmitter. In WAIT it ignores every request until the
// transmitter reports the frame is finished. If TIMEOUT is non-zero, it
// returns to IDLE after TIMEOUT cycles without completion.
//
// Parameters
//   N_REQ    number of requesters (2..8)
//   TIMEOUT  cycles to wait for i_tx_done in WAIT; 0 disables the watchdog
//   OWNER_W  derived width of o_owner ($clog2(N_REQ))
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   i_req       per-requester request level, held until granted
//   i_data      byte k on bits [8k+7:8k]
//   i_tx_done   one-cycle frame-complete pulse from the UART TX
//   o_grant     one-hot one-cycle pulse: that requester's byte was captured
//   o_tx        byte presented to the UART TX, held until the next grant
//   o_tx_start  one-cycle start pulse to the UART TX
//   o_owner     index of the last granted requester
//   o_busy      high whenever the arbiter is not IDLE
//   o_timeout   one-cycle pulse when the watchdog expires
module uart_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int unsigned TIMEOUT = 100000,
  localparam int OWNER_W = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [8*N_REQ-1:0]   i_data,
  input  logic                 i_tx_done,
  output logic [N_REQ-1:0]     o_grant,
  output logic [7:0]           o_tx,
  output logic                 o_tx_start,
  output logic [OWNER_W-1:0]   o_owner,
  output logic                 o_busy,
  output logic                 o_timeout
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t state, state_d;

  logic [OWNER_W-1:0] ptr, ptr_d;
  logic [OWNER_W-1:0] ptr_eff;
  logic [OWNER_W-1:0] win_idx;
  logic               win_valid;
  logic [31:0]        wcnt, wcnt_d;
  int                 cand;

  logic [N_REQ-1:0]   grant_d;
  logic [7:0]         tx_d;
  logic               start_d;
  logic [OWNER_W-1:0] owner_d;
  logic               timeout_d;

  // Pointer codes at or above N_REQ (only possible when N_REQ is not a
  // power of two) are treated as 0 so the search always starts in range.
  assign ptr_eff = (int'(ptr) < N_REQ) ? ptr : '0;

  // Rotating priority search: first asserted request starting at ptr_eff,
  // wrapping past N_REQ-1 back to 0.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = int'(ptr_eff) + off;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      if (!win_valid && i_req[cand[OWNER_W-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[OWNER_W-1:0];
      end
    end
  end

  // Next-state and next-output logic. Pulse outputs default low; o_tx and
  // o_owner hold their last value until the next grant.
  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    wcnt_d    = wcnt;
    grant_d   = '0;
    tx_d      = o_tx;
    start_d   = 1'b0;
    owner_d   = o_owner;
    timeout_d = 1'b0;

    case (state)
      S_IDLE: begin
        if (win_valid) begin
          grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          tx_d    = i_data[8*win_idx +: 8];
          start_d = 1'b1;
          owner_d = win_idx;
          if (int'(win_idx) == N_REQ - 1) begin
            ptr_d = '0;
          end else begin
            ptr_d = win_idx + 1'b1;
          end
          wcnt_d  = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // Frame completion takes priority over a coincident watchdog expiry.
        if (i_tx_done) begin
          state_d = S_IDLE;
        end else if ((TIMEOUT != 0) && (wcnt == TIMEOUT - 1)) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else begin
          wcnt_d = wcnt + 32'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers. Reset is asynchronous so that a reset in
  // the middle of a frame clears the outputs without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      wcnt       <= '0;
      o_grant    <= '0;
      o_tx       <= 8'h00;
      o_tx_start <= 1'b0;
      o_owner    <= '0;
      o_timeout  <= 1'b0;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      wcnt       <= wcnt_d;
      o_grant    <= grant_d;
      o_tx       <= tx_d;
      o_tx_start <= start_d;
      o_owner    <= owner_d;
      o_timeout  <= timeout_d;
    end
  end

  assign o_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter with four requesters. Two
// instances share the same inputs: dut uses the default (long) watchdog,
// dut_wd uses TIMEOUT=8 and is only observed in the watchdog scenario.
// Expected grants come from a round-robin model kept as a plain pointer
// and modular search over the request mask.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic        done;

  logic [3:0]  grant;
  logic [7:0]  tx;
  logic        start;
  logic [1:0]  owner;
  logic        busy;
  logic        tmo;

  logic [3:0]  w_grant;
  logic [7:0]  w_tx;
  logic        w_start;
  logic [1:0]  w_owner;
  logic        w_busy;
  logic        w_tmo;

  int total = 0;
  int bad   = 0;
  int mptr  = 0;

  uart_tx_arbiter #(.N_REQ(4)) dut (
    .clk(clk), .rst(rst), .i_req(req), .i_data(data), .i_tx_done(done),
    .o_grant(grant), .o_tx(tx), .o_tx_start(start), .o_owner(owner),
    .o_busy(busy), .o_timeout(tmo)
  );

  uart_tx_arbiter #(.N_REQ(4), .TIMEOUT(8)) dut_wd (
    .clk(clk), .rst(rst), .i_req(req), .i_data(data), .i_tx_done(done),
    .o_grant(w_grant), .o_tx(w_tx), .o_tx_start(w_start), .o_owner(w_owner),
    .o_busy(w_busy), .o_timeout(w_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    @(negedge clk);
    rst  = 1'b0;
    mptr = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req = 4'b0000; done = 1'b0; data = 32'h0;
    #1;
    total++; if (grant !== 4'b0) begin bad++; $display("[TB] FAIL reset_grant got=%b want=0000", grant); end
    total++; if (tx !== 8'h00) begin bad++; $display("[TB] FAIL reset_tx got=%h want=00", tx); end
    total++; if (start !== 1'b0) begin bad++; $display("[TB] FAIL reset_start got=%b want=0", start); end
    total++; if (owner !== 2'd0) begin bad++; $display("[TB] FAIL reset_owner got=%0d want=0", owner); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    total++; if (tmo !== 1'b0) begin bad++; $display("[TB] FAIL reset_timeout got=%b want=0", tmo); end
    @(negedge clk);
    rst = 1'b0;
    mptr = 0;
  endtask

  task automatic test_single();
    do_reset();
    data = 32'h00A50000;
    req  = 4'b0100;
    tick();
    total++; if (grant !== 4'b0100) begin bad++; $display("[TB] FAIL single_grant got=%b want=0100", grant); end
    total++; if (start !== 1'b1) begin bad++; $display("[TB] FAIL single_start got=%b want=1", start); end
    total++; if (tx !== 8'hA5) begin bad++; $display("[TB] FAIL single_tx got=%h want=a5", tx); end
    total++; if (owner !== 2'd2) begin bad++; $display("[TB] FAIL single_owner got=%0d want=2", owner); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL single_busy got=%b want=1", busy); end
    req = 4'b0000;
    for (int j = 1; j < 20; j++) begin
      tick();
      total++; if (busy !== 1'b1 || start !== 1'b0 || tx !== 8'hA5) begin
        bad++; $display("[TB] FAIL single_wait cyc=%0d busy=%b start=%b tx=%h want busy=1 start=0 tx=a5", j, busy, start, tx);
      end
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single_done_idle got busy=%b want=0", busy); end
  endtask

  task automatic test_fairness();
    int cnt;
    do_reset();
    data = 32'h13121110;
    req  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cnt = 0;
      tick();
      while (start !== 1'b1 && cnt < 10) begin
        tick();
        cnt++;
      end
      total++;
      if (start !== 1'b1) begin
        bad++; $display("[TB] FAIL fair_start_timeout i=%0d got start=%b want=1", i, start);
      end else begin
        if (tx !== 8'(8'h10 + i % 4) || grant !== 4'(1 << (i % 4))) begin
          bad++; $display("[TB] FAIL fair_order i=%0d tx=%h grant=%b want tx=%h grant=%b", i, tx, grant, 8'(8'h10 + i % 4), 4'(1 << (i % 4)));
        end
      end
      for (int j = 1; j <= 5; j++) begin
        tick();
        total++; if (grant !== 4'b0 || start !== 1'b0) begin
          bad++; $display("[TB] FAIL fair_extra_grant i=%0d grant=%b start=%b want 0000/0", i, grant, start);
        end
      end
      done = 1'b1;
      tick();
      done = 1'b0;
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_ptr_wrap();
    do_reset();
    data = 32'hD3000000 | 32'h000000C0;
    req  = 4'b1000;
    tick();
    total++; if (grant !== 4'b1000) begin bad++; $display("[TB] FAIL wrap_first got=%b want=1000", grant); end
    req = 4'b0000;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    req = 4'b1001;
    tick();
    total++; if (grant !== 4'b0001 || tx !== 8'hC0) begin
      bad++; $display("[TB] FAIL wrap_to_zero grant=%b tx=%h want 0001/c0", grant, tx);
    end
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    total++; if (grant !== 4'b1000 || tx !== 8'hD3) begin
      bad++; $display("[TB] FAIL wrap_then_three grant=%b tx=%h want 1000/d3", grant, tx);
    end
    req = 4'b0000;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic test_watchdog();
    do_reset();
    data = 32'h44332211;
    req  = 4'b0010;
    tick();
    total++; if (w_start !== 1'b1 || w_grant !== 4'b0010) begin
      bad++; $display("[TB] FAIL wd_grant start=%b grant=%b want 1/0010", w_start, w_grant);
    end
    req = 4'b0100;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++; if (w_tmo !== (k == 8) || w_busy !== (k != 8)) begin
        bad++; $display("[TB] FAIL wd_count k=%0d timeout=%b busy=%b want %b/%b", k, w_tmo, w_busy, (k == 8), (k != 8));
      end
    end
    tick();
    total++; if (w_grant !== 4'b0100 || w_start !== 1'b1 || w_tx !== 8'h33) begin
      bad++; $display("[TB] FAIL wd_next_grant grant=%b start=%b tx=%h want 0100/1/33", w_grant, w_start, w_tx);
    end
    req = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      if (k == 8) done = 1'b1;
      tick();
      done = 1'b0;
      total++; if (w_tmo !== 1'b0 || w_busy !== (k != 8)) begin
        bad++; $display("[TB] FAIL wd_coincide k=%0d timeout=%b busy=%b want 0/%b", k, w_tmo, w_busy, (k != 8));
      end
    end
  endtask

  task automatic test_spurious();
    do_reset();
    data = 32'hFFFFFFFF;
    done = 1'b1;
    tick();
    done = 1'b0;
    total++; if (grant !== 4'b0 || start !== 1'b0 || busy !== 1'b0 || tx !== 8'h00 || owner !== 2'd0 || tmo !== 1'b0) begin
      bad++; $display("[TB] FAIL spurious_done grant=%b start=%b busy=%b tx=%h owner=%0d tmo=%b want all 0", grant, start, busy, tx, owner, tmo);
    end
    tick();
    total++; if (busy !== 1'b0 || start !== 1'b0) begin
      bad++; $display("[TB] FAIL spurious_after busy=%b start=%b want 0/0", busy, start);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    data = 32'h00C35A00;
    req  = 4'b0100;
    tick();
    total++; if (owner !== 2'd2 || tx !== 8'hC3) begin
      bad++; $display("[TB] FAIL rstwait_setup owner=%0d tx=%h want 2/c3", owner, tx);
    end
    req = 4'b0000;
    tick();
    #2;
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || tx !== 8'h00 || owner !== 2'd0 || grant !== 4'b0 || start !== 1'b0) begin
      bad++; $display("[TB] FAIL rstwait_async busy=%b tx=%h owner=%0d grant=%b start=%b want all 0", busy, tx, owner, grant, start);
    end
    rst = 1'b0;
    req = 4'b0110;
    tick();
    total++; if (grant !== 4'b0010 || owner !== 2'd1 || tx !== 8'h5A) begin
      bad++; $display("[TB] FAIL rstwait_ptr grant=%b owner=%0d tx=%h want 0010/1/5a", grant, owner, tx);
    end
    req = 4'b0000;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic test_back_to_back();
    int last;
    int nstarts;
    logic prev;
    do_reset();
    data = 32'h04030201;
    req  = 4'b1111;
    last = -1;
    nstarts = 0;
    prev = 1'b0;
    for (int cyc = 0; cyc < 21; cyc++) begin
      tick();
      done = prev;
      prev = start;
      if (start === 1'b1) begin
        nstarts++;
        if (last >= 0) begin
          total++; if (cyc - last != 3) begin
            bad++; $display("[TB] FAIL b2b_spacing got=%0d want=3", cyc - last);
          end
        end
        last = cyc;
      end
    end
    total++; if (nstarts != 7) begin bad++; $display("[TB] FAIL b2b_count got=%0d want=7", nstarts); end
    req  = 4'b0000;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [3:0] cur;
    logic [7:0] exp_tx;
    int w;
    int d;
    int gap;
    do_reset();
    data = $urandom;
    cur  = 4'b0000;
    for (int t = 0; t < 60; t++) begin
      if (cur == 4'b0000) begin
        req = 4'b0000;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          done = 1'($urandom_range(0, 1));
          tick();
          done = 1'b0;
          total++; if (busy !== 1'b0 || grant !== 4'b0) begin
            bad++; $display("[TB] FAIL rand_idle t=%0d busy=%b grant=%b want 0/0000", t, busy, grant);
          end
        end
        cur = 4'($urandom_range(1, 15));
      end
      req = cur;
      w = -1;
      for (int off = 0; off < 4; off++) begin
        if (w < 0 && cur[(mptr + off) % 4]) w = (mptr + off) % 4;
      end
      exp_tx = data[8*w +: 8];
      tick();
      total++; if (grant !== 4'(1 << w) || start !== 1'b1 || tx !== exp_tx || owner !== 2'(w) || busy !== 1'b1) begin
        bad++; $display("[TB] FAIL rand_grant t=%0d grant=%b start=%b tx=%h owner=%0d busy=%b want %b/1/%h/%0d/1",
                        t, grant, start, tx, owner, busy, 4'(1 << w), exp_tx, w);
      end
      mptr = (w + 1) % 4;
      cur = cur & ~4'(1 << w);
      if ($urandom_range(0, 3) == 0) cur = cur | 4'(1 << w);
      if ($urandom_range(0, 3) == 0) cur = cur | 4'($urandom);
      req = cur;
      d = $urandom_range(1, 6);
      for (int j = 1; j <= d; j++) begin
        tick();
        total++; if (busy !== 1'b1 || start !== 1'b0 || grant !== 4'b0 || tx !== exp_tx) begin
          bad++; $display("[TB] FAIL rand_wait t=%0d j=%0d busy=%b start=%b grant=%b tx=%h want 1/0/0000/%h", t, j, busy, start, grant, tx, exp_tx);
        end
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      total++; if (busy !== 1'b0 || tmo !== 1'b0 || tx !== exp_tx) begin
        bad++; $display("[TB] FAIL rand_release t=%0d busy=%b tmo=%b tx=%h want 0/0/%h", t, busy, tmo, tx, exp_tx);
      end
    end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    rst  = 1'b0;
    req  = 4'b0000;
    data = 32'h0;
    done = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_ptr_wrap();
    test_watchdog();
    test_spurious();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout got=stuck want=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter between up to eight byte producers, such as the ALU result path, status reporters and debug taps. It sits between the requesters and the UART TX: it accepts one byte per grant, issues the transmitter's start pulse, and holds off further grants until the transmitter reports frame completion. A watchdog releases the transmitter if completion never arrives.

## Interface
- N_REQ, 4: number of requesters; legal range 2..8.
- TIMEOUT, 100000: clock cycles to wait in WAIT for `i_tx_done`; 0 disables the watchdog.
- OWNER_W, derived as `$clog2(N_REQ)`: width of `o_owner`; not overridden.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  N_REQ  per-requester request level; held high until granted.
- i_data  in  8*N_REQ  byte for requester k is on bits [8k+7:8k]; stable while `i_req[k]` is high.
- i_tx_done  in  1  one-cycle pulse from the UART TX when a frame has finished.
- o_grant  out  N_REQ  one-hot, one-cycle pulse: the byte of the indicated requester was captured.
- o_tx  out  8  byte presented to the UART TX; holds its value until the next grant.
- o_tx_start  out  1  one-cycle start pulse to the UART TX.
- o_owner  out  OWNER_W  index of the last granted requester; holds its value.
- o_busy  out  1  high whenever the state is not IDLE.
- o_timeout  out  1  one-cycle pulse when the watchdog expires.

## Operation
- States: IDLE and WAIT.
- Registers: `ptr` (OWNER_W bits, round-robin start index) and `wcnt` (watchdog counter, 32 bits, unsigned).
- Reset values:
  - state IDLE, `ptr` 0, `wcnt` 0.
  - `o_grant` 0, `o_tx` 0x00, `o_tx_start` 0, `o_owner` 0, `o_busy` 0, `o_timeout` 0.
- IDLE, when `|i_req` is true:
  - Winner = the first requester k with `i_req[k]` high, searching ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1.
  - On the next edge: `o_tx` takes the winner's byte, `o_grant[winner]` and `o_tx_start` are 1, `o_owner` takes winner, `ptr` takes (winner+1) mod N_REQ, `wcnt` is cleared, state moves to WAIT.
- IDLE, when `|i_req` is false: hold all state; pulse outputs are 0.
- WAIT:
  - Requests are ignored, including a request that was granted but is still high in this cycle.
  - `i_tx_done` = 1: next state is IDLE.
  - Otherwise, if TIMEOUT ≠ 0 and `wcnt` == TIMEOUT-1: next state is IDLE and `o_timeout` pulses on that edge.
  - Otherwise `wcnt` increments.
  - If `i_tx_done` and the watchdog expiry coincide, `i_tx_done` wins: no `o_timeout` pulse.
- `i_tx_done` seen in IDLE is ignored and has no side effects.
- Pulse outputs (`o_grant`, `o_tx_start`, `o_timeout`) default to 0 every cycle unless set as above.
- `ptr` wraps from N_REQ-1 to 0.
- Unused `ptr` codes, possible when N_REQ is not a power of two, cannot occur. The search logic treats them as 0.
- A requester that keeps `i_req` high after its grant is requesting its next byte and competes normally.

## Timing
- Grant latency: a request sampled high in IDLE at edge t produces `o_grant`, `o_tx_start` and a valid `o_tx` in the cycle after edge t, i.e. one registered cycle.
- `o_tx` is valid in the same cycle as `o_tx_start` and stays stable through WAIT.
- `o_busy` rises with `o_tx_start` and falls in the cycle after `i_tx_done` is sampled.
- Minimum spacing between consecutive `o_tx_start` pulses is 3 cycles: start, then at least one WAIT cycle with done, then IDLE.
- All requesters continuously requesting: grant order is 0,1,2,3,0,… for N_REQ=4.
- Reset asserted mid-WAIT: outputs return to reset values immediately, without waiting for a clock edge. A frame already in flight in the UART TX is not aborted by this block. Its later `i_tx_done` arrives in IDLE and is ignored.

## Test plan
- Single request:
  - Stimulus: `i_req`=0b0100, byte 2 = 0xA5.
  - Response: one cycle later `o_grant`=0b0100, `o_tx_start`=1, `o_tx`=0xA5, `o_owner`=2, `o_busy`=1.
  - Then: `i_tx_done` pulse 20 cycles later leads to IDLE on the following cycle.
- Fairness:
  - Stimulus: `i_req`=0b1111 held, bytes 0x10/0x11/0x12/0x13, `i_tx_done` 5 cycles after each start.
  - Response: `o_tx` sequence 0x10, 0x11, 0x12, 0x13, 0x10; exactly one grant per start.
- Pointer wrap:
  - Stimulus: grant requester 3, then `i_req`=0b1001.
  - Response: requester 0 is granted next (`ptr`=0), then requester 3.
- Watchdog:
  - Stimulus: TIMEOUT=8, one request, no `i_tx_done`.
  - Response: `o_timeout` pulses 8 cycles after `o_tx_start`; state returns to IDLE; the next pending request is granted one cycle later.
  - Coincidence: `i_tx_done` on that same cycle produces no `o_timeout`.
- Spurious and reset cases:
  - `i_tx_done` pulsed in IDLE with `i_req`=0: no output change.
  - `rst` pulsed mid-WAIT: `o_busy`, `o_tx` and `o_owner` are 0 with no clock edge required; `ptr` is 0, so with `i_req`=0b0110 requester 1 is granted first.
- Back-to-back spacing:
  - Stimulus: `i_tx_done` given in the first WAIT cycle.
  - Response: consecutive `o_tx_start` pulses are exactly 3 cycles apart.
